// File: rtl/datamem_pkg.sv
// Shared constants for the data-memory arbiter: FSM encoding, default widths
// and the arbitration-mode selectors.
package datamem_pkg;

    localparam int unsigned DM_ADDR_W = 8;
    localparam int unsigned DM_DATA_W = 8;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/datamem_rr_pick.sv
// Combinational two-way picker: round-robin on a tie (the port that did not
// win last time) unless prio_mode forces port 0.
module datamem_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic prio_mode,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            grant_id = prio_mode ? 1'b0 : ~last_grant;
        end else if (req1) begin
            grant_id = 1'b1;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter for the single-port data memory. Each access takes
// IDLE -> ACCESS -> RESP; the memory acts on the falling edge inside ACCESS.
module datamem_arbiter
    import datamem_pkg::*;
#(
    parameter int unsigned ADDR_W    = DM_ADDR_W,
    parameter int unsigned DATA_W    = DM_DATA_W,
    parameter int unsigned PRIO_MODE = PRIO_RR
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam logic PRIO_BIT = (PRIO_MODE == PRIO_FIXED);

    logic [1:0]        state_q,      state_d;
    logic              win_q,        win_d;
    logic              last_grant_q, last_grant_d;
    logic              ack0_q,       ack0_d;
    logic              ack1_q,       ack1_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;
    logic              mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              busy_q,       busy_d;

    logic grant_valid;
    logic grant_id;

    datamem_rr_pick u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant_q),
        .prio_mode   (PRIO_BIT),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            win_q        <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    // Next state; acks and mem_write are single-cycle, everything else holds
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d      = ST_ACCESS;
                    win_d        = grant_id;
                    last_grant_d = grant_id;
                    mem_write_d  = grant_id ? we1    : we0;
                    mem_addr_d   = grant_id ? addr1  : addr0;
                    mem_wdata_d  = grant_id ? wdata1 : wdata0;
                end
            end
            ST_ACCESS: begin
                // mem_write_q still tells us whether this access is a write
                state_d = ST_RESP;
                if (win_q) begin
                    ack1_d = 1'b1;
                    if (!mem_write_q) begin
                        rdata1_d = mem_rdata;
                    end
                end else begin
                    ack0_d = 1'b1;
                    if (!mem_write_q) begin
                        rdata0_d = mem_rdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

    // Structural invariants of the access sequence
    a_write_only_in_access: assert property (@(posedge clk) disable iff (!rst_n)
        mem_write_q |-> (state_q == ST_ACCESS));
    a_ack_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
        (ack0_q || ack1_q) |-> (state_q == ST_RESP));
    a_acks_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(ack0_q && ack1_q));
    a_busy_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state_q != ST_IDLE));

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: a round-robin and a fixed-priority instance, each
// with its own falling-edge memory and a transaction-level reference model.
module tb_datamem_arbiter;

    localparam int NI = 2;

    logic clk;
    logic rst_n;

    logic       req0_s [NI];
    logic       we0_s  [NI];
    logic [7:0] addr0_s [NI];
    logic [7:0] wdata0_s [NI];
    logic       req1_s [NI];
    logic       we1_s  [NI];
    logic [7:0] addr1_s [NI];
    logic [7:0] wdata1_s [NI];

    logic       ack0_w [NI];
    logic       ack1_w [NI];
    logic [7:0] rdata0_w [NI];
    logic [7:0] rdata1_w [NI];
    logic       mem_write_w [NI];
    logic [7:0] mem_addr_w [NI];
    logic [7:0] mem_wdata_w [NI];
    logic [7:0] mem_rdata_w [NI];
    logic       busy_w [NI];

    datamem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_s[0]), .we0(we0_s[0]), .addr0(addr0_s[0]), .wdata0(wdata0_s[0]),
        .ack0(ack0_w[0]), .rdata0(rdata0_w[0]),
        .req1(req1_s[0]), .we1(we1_s[0]), .addr1(addr1_s[0]), .wdata1(wdata1_s[0]),
        .ack1(ack1_w[0]), .rdata1(rdata1_w[0]),
        .mem_write(mem_write_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0]),
        .busy(busy_w[0])
    );

    datamem_arbiter #(.ADDR_W(8), .DATA_W(8), .PRIO_MODE(1)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_s[1]), .we0(we0_s[1]), .addr0(addr0_s[1]), .wdata0(wdata0_s[1]),
        .ack0(ack0_w[1]), .rdata0(rdata0_w[1]),
        .req1(req1_s[1]), .we1(we1_s[1]), .addr1(addr1_s[1]), .wdata1(wdata1_s[1]),
        .ack1(ack1_w[1]), .rdata1(rdata1_w[1]),
        .mem_write(mem_write_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1]),
        .busy(busy_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memories: write and read-address latch on the falling edge
    logic [7:0] mem [NI][256];
    logic [7:0] lat_addr [NI];
    bit         mem_clr_done;
    logic       pl_en;
    int         pl_inst;
    logic [7:0] pl_addr;
    logic [7:0] pl_data;

    always @(negedge clk) begin
        if (!mem_clr_done) begin
            for (int i = 0; i < NI; i++) begin
                for (int a = 0; a < 256; a++) mem[i][a] = 8'h00;
                lat_addr[i] = 8'h00;
            end
            mem_clr_done = 1'b1;
        end
        if (pl_en) mem[pl_inst][pl_addr] = pl_data;
        for (int i = 0; i < NI; i++) begin
            if (mem_write_w[i]) mem[i][mem_addr_w[i]] = mem_wdata_w[i];
            lat_addr[i] = mem_addr_w[i];
        end
    end

    assign mem_rdata_w[0] = mem[0][lat_addr[0]];
    assign mem_rdata_w[1] = mem[1][lat_addr[1]];

    // Reference model: an access occupies the memory for three edges
    // (grant, completion, recovery); memory effects land at completion.
    int         m_left [NI];
    bit         m_lg   [NI];
    bit         m_win  [NI];
    bit         m_we   [NI];
    logic [7:0] m_addr [NI];
    logic [7:0] m_wd   [NI];
    logic [7:0] ref_mem [NI][256];

    bit         e_ack0 [NI];
    bit         e_ack1 [NI];
    bit         e_mw   [NI];
    bit         e_busy [NI];
    logic [7:0] e_rd0  [NI];
    logic [7:0] e_rd1  [NI];
    logic [7:0] e_maddr [NI];
    logic [7:0] e_mwd  [NI];

    int n_checks;
    int n_fail;

    function automatic void chk(input string name, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got 0x%0h, expected 0x%0h", name, i, $time, act, exp);
        end
    endfunction

    function automatic void model_reset_one(input int i);
        m_left[i]  = 0;
        m_lg[i]    = 1'b1;
        e_ack0[i]  = 1'b0;
        e_ack1[i]  = 1'b0;
        e_mw[i]    = 1'b0;
        e_busy[i]  = 1'b0;
        e_rd0[i]   = 8'h00;
        e_rd1[i]   = 8'h00;
        e_maddr[i] = 8'h00;
        e_mwd[i]   = 8'h00;
    endfunction

    function automatic void model_edge(input int i);
        if (!rst_n) begin
            model_reset_one(i);
            return;
        end
        e_ack0[i] = 1'b0;
        e_ack1[i] = 1'b0;
        if (m_left[i] == 2) begin
            m_left[i] = 1;
            e_mw[i]   = 1'b0;
            if (m_we[i]) ref_mem[i][m_addr[i]] = m_wd[i];
            else if (m_win[i]) e_rd1[i] = ref_mem[i][m_addr[i]];
            else e_rd0[i] = ref_mem[i][m_addr[i]];
            if (m_win[i]) e_ack1[i] = 1'b1;
            else e_ack0[i] = 1'b1;
        end else if (m_left[i] == 1) begin
            m_left[i] = 0;
        end else if (req0_s[i] || req1_s[i]) begin
            if (req0_s[i] && req1_s[i]) m_win[i] = (i == 1) ? 1'b0 : !m_lg[i];
            else m_win[i] = req1_s[i];
            m_lg[i]    = m_win[i];
            m_we[i]    = m_win[i] ? we1_s[i] : we0_s[i];
            m_addr[i]  = m_win[i] ? addr1_s[i] : addr0_s[i];
            m_wd[i]    = m_win[i] ? wdata1_s[i] : wdata0_s[i];
            e_mw[i]    = m_we[i];
            e_maddr[i] = m_addr[i];
            e_mwd[i]   = m_wd[i];
            m_left[i]  = 2;
        end
        e_busy[i] = (m_left[i] != 0);
    endfunction

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("ack0", i, int'(ack0_w[i]), int'(e_ack0[i]));
            chk("ack1", i, int'(ack1_w[i]), int'(e_ack1[i]));
            chk("rdata0", i, int'(rdata0_w[i]), int'(e_rd0[i]));
            chk("rdata1", i, int'(rdata1_w[i]), int'(e_rd1[i]));
            chk("mem_write", i, int'(mem_write_w[i]), int'(e_mw[i]));
            chk("mem_addr", i, int'(mem_addr_w[i]), int'(e_maddr[i]));
            chk("mem_wdata", i, int'(mem_wdata_w[i]), int'(e_mwd[i]));
            chk("busy", i, int'(busy_w[i]), int'(e_busy[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) model_edge(i);
        check_all();
    endtask

    task automatic set_cmd(input int i, input int p, input bit r, input bit w,
                           input logic [7:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0_s[i] = r; we0_s[i] = w; addr0_s[i] = a; wdata0_s[i] = d;
        end else begin
            req1_s[i] = r; we1_s[i] = w; addr1_s[i] = a; wdata1_s[i] = d;
        end
    endtask

    task automatic preload(input int i, input logic [7:0] a, input logic [7:0] d);
        pl_inst = i; pl_addr = a; pl_data = d; pl_en = 1'b1;
        ref_mem[i][a] = d;
        @(negedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    function automatic bit ack_of(input int i, input int p);
        return (p == 0) ? ack0_w[i] : ack1_w[i];
    endfunction

    function automatic logic [7:0] rd_of(input int i, input int p);
        return (p == 0) ? rdata0_w[i] : rdata1_w[i];
    endfunction

    typedef struct {
        int         inst;
        int         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    task automatic run_vec(input vec_t v);
        int edges;
        int mw;
        bit seen;
        edges = 0; mw = 0; seen = 1'b0;
        set_cmd(v.inst, v.port, 1'b1, v.we, v.addr, v.wdata);
        while (!seen && edges < 8) begin
            step();
            edges++;
            if (mem_write_w[v.inst]) mw++;
            if (ack_of(v.inst, v.port)) seen = 1'b1;
        end
        chk("vec_ack_latency", v.inst, edges, 2);
        chk("vec_rdata", v.inst, int'(rd_of(v.inst, v.port)), int'(v.exp_rd));
        chk("vec_write_pulses", v.inst, mw, int'(v.we));
        set_cmd(v.inst, v.port, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        int ack_idx [$];
        int ack_port [$];
        int fx0;
        int fx1;
        int w;
        bit got;

        n_checks = 0;
        n_fail   = 0;
        pl_en    = 1'b0;
        pl_inst  = 0;
        pl_addr  = 8'h00;
        pl_data  = 8'h00;
        for (int i = 0; i < NI; i++) begin
            for (int a = 0; a < 256; a++) ref_mem[i][a] = 8'h00;
            set_cmd(i, 0, 1'b0, 1'b0, 8'h00, 8'h00);
            set_cmd(i, 1, 1'b0, 1'b0, 8'h00, 8'h00);
            m_win[i] = 1'b0; m_we[i] = 1'b0; m_addr[i] = 8'h00; m_wd[i] = 8'h00;
            model_reset_one(i);
        end

        vecs[0]  = '{0, 0, 1'b1, 8'h10, 8'h3C, 8'h00};
        vecs[1]  = '{0, 0, 1'b0, 8'h10, 8'h00, 8'h3C};
        vecs[2]  = '{0, 1, 1'b1, 8'hFF, 8'hFF, 8'h00};
        vecs[3]  = '{0, 0, 1'b0, 8'hFF, 8'h00, 8'hFF};
        vecs[4]  = '{0, 0, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{1, 0, 1'b1, 8'h10, 8'h3C, 8'h00};
        vecs[6]  = '{1, 0, 1'b0, 8'h10, 8'h00, 8'h3C};
        vecs[7]  = '{1, 1, 1'b1, 8'hFF, 8'hFF, 8'h00};
        vecs[8]  = '{1, 1, 1'b0, 8'hFF, 8'h00, 8'hFF};
        vecs[9]  = '{0, 1, 1'b1, 8'h00, 8'h77, 8'h00};
        vecs[10] = '{0, 1, 1'b0, 8'h00, 8'h00, 8'h77};
        vecs[11] = '{0, 0, 1'b0, 8'h00, 8'h00, 8'h77};

        // Reset held 3 cycles with both ports of the round-robin instance requesting
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        set_cmd(0, 0, 1'b1, 1'b0, 8'h05, 8'h00);
        set_cmd(0, 1, 1'b1, 1'b0, 8'h06, 8'h00);
        #1;
        check_all();
        repeat (3) step();
        rst_n = 1'b1;
        first = -1;
        for (int k = 0; k < 12 && (req0_s[0] || req1_s[0]); k++) begin
            step();
            if (ack0_w[0]) begin
                if (first < 0) first = 0;
                req0_s[0] = 1'b0;
            end
            if (ack1_w[0]) begin
                if (first < 0) first = 1;
                req1_s[0] = 1'b0;
            end
        end
        chk("reset_first_grant", 0, first, 0);
        chk("reset_both_served", 0, int'(req0_s[0] | req1_s[0]), 0);
        step();

        for (int n = 0; n < 12; n++) run_vec(vecs[n]);

        // Both ports hold reads continuously on both instances
        preload(0, 8'h20, 8'hA5);
        preload(0, 8'h21, 8'h5A);
        preload(1, 8'h20, 8'hA5);
        preload(1, 8'h21, 8'h5A);
        for (int i = 0; i < NI; i++) begin
            set_cmd(i, 0, 1'b1, 1'b0, 8'h20, 8'h00);
            set_cmd(i, 1, 1'b1, 1'b0, 8'h21, 8'h00);
        end
        fx0 = 0; fx1 = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (ack0_w[0]) begin ack_idx.push_back(k); ack_port.push_back(0); end
            if (ack1_w[0]) begin ack_idx.push_back(k); ack_port.push_back(1); end
            if (ack0_w[1]) fx0++;
            if (ack1_w[1]) fx1++;
        end
        chk("rr_ack_count", 0, ack_port.size(), 4);
        for (int j = 1; j < ack_port.size(); j++) begin
            chk("rr_alternate", 0, int'(ack_port[j] != ack_port[j-1]), 1);
            chk("rr_ack_spacing", 0, ack_idx[j] - ack_idx[j-1], 3);
        end
        chk("rr_rdata0", 0, int'(rdata0_w[0]), 8'hA5);
        chk("rr_rdata1", 0, int'(rdata1_w[0]), 8'h5A);
        chk("fx_port0_acks", 1, fx0, 4);
        chk("fx_port1_starved", 1, fx1, 0);
        set_cmd(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_cmd(0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_cmd(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        w = 0; got = 1'b0;
        while (!got && w < 8) begin
            step();
            w++;
            if (ack1_w[1]) got = 1'b1;
        end
        chk("fx_port1_after_drop", 1, int'(got), 1);
        chk("fx_rdata1", 1, int'(rdata1_w[1]), 8'h5A);
        set_cmd(1, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();

        // Reset asserted in the middle of a port 0 write
        set_cmd(0, 0, 1'b1, 1'b1, 8'h40, 8'h99);
        step();
        chk("pre_reset_mem_write", 0, int'(mem_write_w[0]), 1);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) model_reset_one(i);
        #1;
        chk("rst_mem_write_async", 0, int'(mem_write_w[0]), 0);
        chk("rst_busy_async", 0, int'(busy_w[0]), 0);
        check_all();
        set_cmd(0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        run_vec('{0, 0, 1'b0, 8'h10, 8'h00, 8'h3C});

        // Randomized traffic; requesters react to the model's acks
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                for (int p = 0; p < 2; p++) begin
                    bit r;
                    bit a;
                    logic [7:0] ad;
                    r = (p == 0) ? req0_s[i] : req1_s[i];
                    a = (p == 0) ? e_ack0[i] : e_ack1[i];
                    case ($urandom_range(0, 7))
                        0:       ad = 8'h00;
                        1:       ad = 8'hFF;
                        default: ad = 8'(8'h30 + $urandom_range(0, 15));
                    endcase
                    if (r && a) begin
                        if ($urandom_range(0, 1) == 1)
                            set_cmd(i, p, 1'b1, 1'($urandom_range(0, 1)), ad, 8'($urandom_range(0, 255)));
                        else
                            set_cmd(i, p, 1'b0, 1'b0, 8'h00, 8'h00);
                    end else if (!r && $urandom_range(0, 2) == 0) begin
                        set_cmd(i, p, 1'b1, 1'($urandom_range(0, 1)), ad, 8'($urandom_range(0, 255)));
                    end
                end
            end
            step();
        end
        for (int i = 0; i < NI; i++) begin
            set_cmd(i, 0, 1'b0, 1'b0, 8'h00, 8'h00);
            set_cmd(i, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single-port 256-byte data memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/DMA loader).
- Arbitrates between them, sequences each access to match the memory's timing, and returns read data with a one-cycle ack pulse.
- Memory timing: writes and read-address latching happen on the falling clock edge; read data is valid combinationally from the latched address.
- Sits between the requesters and the memory; it is the only block that drives the memory's write, address and data-in pins.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W.
- DATA_W, 8, data width.
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; hold high with the command stable until ack0.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  DATA_W  port 0 read data; valid while ack0 is high, held afterwards.
- req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1.
- mem_write  out  1  to the memory write pin.
- mem_addr  out  ADDR_W  to the memory address pin.
- mem_wdata  out  DATA_W  to the memory data-in pin.
- mem_rdata  in  DATA_W  from the memory data-out pin.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values (immediate on rst_n low):
  - state = IDLE.
  - ack0 = ack1 = 0; rdata0 = rdata1 = 0.
  - mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0; last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If req0 or req1 is high, pick a winner.
  - Latch the winner's we/addr/wdata into mem_write/mem_addr/mem_wdata, record the winner, and go to ACCESS.
  - Otherwise stay in IDLE, with mem_write = 0 and mem_addr/mem_wdata holding their previous values.
- Arbitration:
  - If only one request is high, that port wins.
  - If both are high and PRIO_MODE = 0, the port that is not last_grant wins.
  - If both are high and PRIO_MODE = 1, port 0 wins.
  - last_grant updates on the IDLE→ACCESS transition.
- ACCESS (exactly 1 cycle):
  - Memory outputs are stable for the whole cycle; the memory commits the write, or latches the read address, on the falling edge mid-cycle.
  - On the rising edge ending ACCESS:
    - mem_write <= 0.
    - For a read: rdata of the winner <= mem_rdata.
    - For a write: rdata of the winner is unchanged.
    - ack of the winner <= 1.
    - Go to RESP.
- RESP (1 cycle):
  - The winner's ack is high and its rdata is valid.
  - On the next edge: ack <= 0, go to IDLE.
- Latency and throughput:
  - A request sampled at edge N gets ack high during cycle N+2, i.e. 2 cycles from the sampling edge.
  - Maximum throughput is one access per 3 cycles.
- Requester rules:
  - The requester must drop req, or present a new command, in the cycle after ack.
  - A req still high when IDLE is re-entered counts as a new transaction.
  - The losing port's req stays pending with no ack; it is served in the next IDLE.
- Non-winner ports: ack is never asserted and rdata holds its value.
- Address handling: no address arithmetic; addr passes straight through. 0xFF and 0x00 are ordinary addresses with no wrap logic.
- Reset mid-operation: an rst_n assertion in ACCESS or RESP drops mem_write and ack immediately and abandons the transaction, with no ack. Whether a write in flight is committed to memory is undefined; software re-issues it.
- mem_write must never be high outside ACCESS.

Decomposition:
- Package datamem_pkg holds:
  - State encoding IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Default ADDR_W / DATA_W constants.
  - PRIO_RR = 0 and PRIO_FIXED = 1.
- One sub-module: datamem_rr_pick, a combinational 2-way picker.
  - Inputs: req0, req1, last_grant, prio_mode.
  - Outputs: grant_valid, grant_id.
  - Instantiated once.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with req0 = 1 → all outputs zero, busy = 0, no mem_write pulse; after release, port 0 is served first.
- Port 0 writes 0x3C to 0x10, then reads 0x10 → mem_write high for exactly 1 cycle; ack0 high 2 cycles after each req sample; rdata0 = 0x3C; ack1 never asserted.
- Both ports read (port 0 at 0x20 preloaded with 0xA5, port 1 at 0x21 preloaded with 0x5A), with req held continuously and PRIO_MODE = 0 → grants alternate 0,1,0,1; rdata0 = 0xA5, rdata1 = 0x5A; one ack every 3 cycles.
- Same stimulus with PRIO_MODE = 1 → port 0 wins every arbitration; port 1 is acked only after req0 drops.
- Port 1 writes 0xFF to address 0xFF, then port 0 reads 0xFF and 0x00 → rdata0 = 0xFF, then 0x00; no wrap side-effects.
- Assert rst_n low during ACCESS of a port 0 write → mem_write and busy fall asynchronously; no ack0; FSM is in IDLE after release and serves the next request normally.
